// File: rtl/console_uart_tx.sv
// Memory-mapped console transmitter: bus-writable TX FIFO feeding an 8N1 serialiser.
// Read data is registered to match the interconnect's one-cycle response path.
module console_uart_tx #(
   parameter int DataWidth    = 32,
   parameter int AddressWidth = 32,
   parameter int FifoDepth    = 8,
   parameter int ClkDiv       = 868
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    req_i,
   input  logic [AddressWidth-1:0] addr_i,
   input  logic                    we_i,
   input  logic [DataWidth-1:0]    wdata_i,
   output logic [DataWidth-1:0]    rdata_o,
   output logic                    tx_o,
   output logic                    irq_o
);

   localparam int CW = $clog2(FifoDepth + 1);
   localparam int PW = $clog2(FifoDepth);
   localparam int BW = $clog2(ClkDiv);

   localparam logic [1:0] REG_TXDATA = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t                 r_state;
   logic [BW-1:0]          r_bcnt;
   logic [2:0]             r_idx;
   logic [7:0]             r_shift;
   logic                   r_tx;

   logic [7:0]             r_mem [FifoDepth];
   logic [PW-1:0]          r_wptr;
   logic [PW-1:0]          r_rptr;
   logic [CW-1:0]          r_count;
   logic                   r_ovf;
   logic                   r_irq_en;
   logic                   r_irq;
   logic [DataWidth-1:0]   r_rdata;

   logic [1:0]             w_sel;
   logic                   w_wr;
   logic                   w_rd;
   logic                   w_pop;
   logic                   w_push_req;
   logic                   w_push;
   logic                   w_ovf_set;
   logic                   w_ovf_clr;
   logic                   w_bit_end;
   logic                   w_idle_nxt;
   logic                   w_irq_en_nxt;
   logic [CW-1:0]          w_count_nxt;
   logic [DataWidth-1:0]   w_status;
   logic [DataWidth-1:0]   w_rdata_nxt;
   logic                   w_unused_bits;

   assign w_sel      = addr_i[3:2];
   assign w_wr       = req_i & we_i;
   assign w_rd       = req_i & ~we_i;
   assign w_bit_end  = (r_bcnt == BW'(ClkDiv - 1));

   // The serialiser drains the FIFO only from IDLE; a simultaneous pop frees
   // a slot, so a write to a full FIFO in that cycle is still accepted.
   assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
   assign w_push_req = w_wr && (w_sel == REG_TXDATA);
   assign w_push     = w_push_req && ((r_count < CW'(FifoDepth)) || w_pop);
   assign w_ovf_set  = w_push_req && !w_push;
   assign w_ovf_clr  = w_wr && (w_sel == REG_STATUS) && wdata_i[3];

   assign w_count_nxt  = r_count + CW'(w_push) - CW'(w_pop);
   assign w_irq_en_nxt = (w_wr && (w_sel == REG_CTRL)) ? wdata_i[0] : r_irq_en;
   assign w_idle_nxt   = ((r_state == S_IDLE) && !w_pop) ||
                         ((r_state == S_STOP) && w_bit_end);

   assign w_unused_bits = ^{addr_i[AddressWidth-1:4], addr_i[1:0], wdata_i[DataWidth-1:8]};

   always_comb begin
      w_status              = '0;
      w_status[8 +: CW]     = r_count;
      w_status[3]           = r_ovf;
      w_status[2]           = (r_count == '0);
      w_status[1]           = (r_count == CW'(FifoDepth));
      w_status[0]           = (r_state != S_IDLE);
   end

   always_comb begin
      w_rdata_nxt = '0;
      if (w_rd) begin
         case (w_sel)
            REG_STATUS: w_rdata_nxt = w_status;
            REG_CTRL:   w_rdata_nxt[0] = r_irq_en;
            default:    w_rdata_nxt = '0;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wptr] <= wdata_i[7:0];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
         r_irq_en <= 1'b0;
         r_irq    <= 1'b0;
         r_rdata  <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop)  r_rptr <= r_rptr + PW'(1);
         r_count  <= w_count_nxt;
         if (w_ovf_set)      r_ovf <= 1'b1;
         else if (w_ovf_clr) r_ovf <= 1'b0;
         r_irq_en <= w_irq_en_nxt;
         r_irq    <= (w_count_nxt == '0) && w_idle_nxt && w_irq_en_nxt;
         r_rdata  <= w_rdata_nxt;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_bcnt  <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_tx <= 1'b1;
               if (w_pop) begin
                  r_shift <= r_mem[r_rptr];
                  r_bcnt  <= '0;
                  r_state <= S_START;
                  r_tx    <= 1'b0;
               end
            end
            S_START: begin
               if (w_bit_end) begin
                  r_bcnt  <= '0;
                  r_idx   <= '0;
                  r_state <= S_DATA;
                  r_tx    <= r_shift[0];
               end else begin
                  r_bcnt  <= r_bcnt + BW'(1);
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  r_bcnt <= '0;
                  if (r_idx == 3'd7) begin
                     r_state <= S_STOP;
                     r_tx    <= 1'b1;
                  end else begin
                     r_idx   <= r_idx + 3'd1;
                     r_shift <= r_shift >> 1;
                     r_tx    <= r_shift[1];
                  end
               end else begin
                  r_bcnt <= r_bcnt + BW'(1);
               end
            end
            S_STOP: begin
               if (w_bit_end) begin
                  r_bcnt  <= '0;
                  r_state <= S_IDLE;
               end else begin
                  r_bcnt  <= r_bcnt + BW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign rdata_o = r_rdata;
   assign tx_o    = r_tx;
   assign irq_o   = r_irq;

endmodule

// File: tb/tb_console_uart_tx.sv
// Directed bench for console_uart_tx with ClkDiv=4, FifoDepth=4.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_console_uart_tx;

   localparam int DW = 32;
   localparam int AW = 32;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b0;
   logic          req_i = 1'b0;
   logic [AW-1:0] addr_i = '0;
   logic          we_i = 1'b0;
   logic [DW-1:0] wdata_i = '0;
   logic [DW-1:0] rdata_o;
   logic          tx_o;
   logic          irq_o;

   int checks = 0;
   int failures = 0;

   console_uart_tx #(
      .DataWidth(DW), .AddressWidth(AW), .FifoDepth(4), .ClkDiv(4)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
      .wdata_i(wdata_i), .rdata_o(rdata_o), .tx_o(tx_o), .irq_o(irq_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic bus_write(input logic [1:0] r, input logic [31:0] d);
      req_i = 1'b1; we_i = 1'b1; addr_i = {28'd0, r, 2'b00}; wdata_i = d;
      tick();
      req_i = 1'b0; we_i = 1'b0; wdata_i = '0;
   endtask

   task automatic bus_read(input logic [1:0] r, output logic [31:0] d);
      req_i = 1'b1; we_i = 1'b0; addr_i = {28'd0, r, 2'b00};
      tick();
      d = rdata_o;
      req_i = 1'b0;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      ticks(2);
      rst_i = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      do_reset();
      checks++; if (tx_o !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx_o); end
      checks++; if (rdata_o !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata_o); end
      checks++; if (irq_o !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq_o); end
      bus_read(2'd1, d);
      checks++; if (d !== 32'h4) begin failures++; $display("FAIL reset_status got=%h exp=00000004", d); end
   endtask

   task automatic test_regs();
      logic [31:0] d;
      do_reset();
      bus_write(2'd2, 32'hFFFF_FFFE);
      bus_read(2'd2, d);
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL ctrl_bit0_only got=%h exp=0", d); end
      bus_write(2'd3, 32'hFFFF_FFFF);
      bus_read(2'd3, d);
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL reserved_read got=%h exp=0", d); end
      bus_read(2'd1, d);
      checks++; if (d !== 32'h4) begin failures++; $display("FAIL status_after_misc got=%h exp=4", d); end
      tick();
      checks++; if (rdata_o !== 32'h0) begin failures++; $display("FAIL rdata_zero_idle got=%h exp=0", rdata_o); end
   endtask

   task automatic test_frame();
      logic [9:0] frame;
      int         waited;
      frame = {1'b1, 8'hA5, 1'b0};
      do_reset();
      bus_write(2'd0, 32'h0000_00A5);
      waited = 0;
      while (tx_o !== 1'b0 && waited < 8) begin tick(); waited++; end
      checks++; if (waited != 1) begin failures++; $display("FAIL frame_start_latency got=%0d exp=1", waited); end
      for (int i = 0; i < 40; i++) begin
         checks++;
         if (tx_o !== frame[i/4]) begin
            failures++; $display("FAIL frame_bit cyc=%0d got=%b exp=%b", i, tx_o, frame[i/4]);
         end
         if (i == 21) begin
            checks++;
            if (rdata_o !== 32'h5) begin failures++; $display("FAIL frame_busy_status got=%h exp=5", rdata_o); end
            req_i = 1'b0;
         end
         if (i == 20) begin req_i = 1'b1; we_i = 1'b0; addr_i = 32'h4; end
         tick();
      end
      checks++; if (tx_o !== 1'b1) begin failures++; $display("FAIL frame_idle_after got=%b exp=1", tx_o); end
   endtask

   task automatic test_overflow();
      logic [31:0] d;
      do_reset();
      bus_write(2'd0, 32'h11);
      tick();
      for (int i = 0; i < 5; i++) bus_write(2'd0, 32'h20 + i);
      bus_read(2'd1, d);
      checks++; if (d !== 32'h40B) begin failures++; $display("FAIL ovf_status got=%h exp=0000040b", d); end
      bus_write(2'd1, 32'h8);
      bus_read(2'd1, d);
      checks++; if (d !== 32'h403) begin failures++; $display("FAIL ovf_clear got=%h exp=00000403", d); end
   endtask

   // First frame enters START at edge 1 and returns to IDLE at edge 41;
   // the write that ends at edge 42 coincides with the IDLE pop.
   task automatic test_full_pop();
      logic [31:0] d;
      do_reset();
      bus_write(2'd0, 32'h11);
      tick();
      for (int i = 0; i < 4; i++) bus_write(2'd0, 32'h30 + i);
      bus_read(2'd1, d);
      checks++; if (d !== 32'h403) begin failures++; $display("FAIL fullpop_pre got=%h exp=00000403", d); end
      ticks(35);
      bus_write(2'd0, 32'h3C);
      bus_read(2'd1, d);
      checks++; if (d !== 32'h403) begin failures++; $display("FAIL fullpop_accept got=%h exp=00000403", d); end
   endtask

   task automatic test_irq();
      logic [31:0] d;
      int          k;
      do_reset();
      bus_write(2'd2, 32'h1);
      checks++; if (irq_o !== 1'b1) begin failures++; $display("FAIL irq_idle_en got=%b exp=1", irq_o); end
      bus_read(2'd2, d);
      checks++; if (d !== 32'h1) begin failures++; $display("FAIL ctrl_read got=%h exp=1", d); end
      bus_write(2'd0, 32'h55);
      checks++; if (irq_o !== 1'b0) begin failures++; $display("FAIL irq_after_push got=%b exp=0", irq_o); end
      k = 0;
      while (irq_o !== 1'b1 && k < 60) begin tick(); k++; end
      checks++;
      if (k < 41 || k > 42) begin failures++; $display("FAIL irq_frame_end got=%0d exp=41..42", k); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      do_reset();
      bus_write(2'd0, 32'h00);
      tick();
      bus_write(2'd0, 32'h01);
      bus_write(2'd0, 32'h02);
      ticks(5);
      checks++; if (tx_o !== 1'b0) begin failures++; $display("FAIL mid_data_low got=%b exp=0", tx_o); end
      rst_i = 1'b1;
      tick();
      checks++; if (tx_o !== 1'b1) begin failures++; $display("FAIL mid_reset_tx got=%b exp=1", tx_o); end
      rst_i = 1'b0;
      bus_read(2'd1, d);
      checks++; if (d !== 32'h4) begin failures++; $display("FAIL mid_reset_status got=%h exp=4", d); end
   endtask

   initial begin
      test_reset();
      test_regs();
      test_frame();
      test_overflow();
      test_full_pop();
      test_irq();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
